// File: rtl/perf_trace_monitor_pkg.sv
// Shared definitions for the performance/trace monitor of the stage_7 memory-to-memory CPU.
// The CPU control unit and the stage_7 benches use the same defaults.
package perf_trace_monitor_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int STATE_W_DEF = 16;
    localparam int CNT_W_DEF   = 32;
    localparam int DEPTH_DEF   = 8;

    // Control-state encoding that marks the first cycle of every instruction.
    localparam logic [STATE_W_DEF-1:0] FETCH_STATE_DEF = '0;

    // Effective FIFO operation on one edge, encoded as {push, pop}.
    typedef enum logic [1:0] {
        FIFO_HOLD = 2'b00,
        FIFO_POP  = 2'b01,
        FIFO_PUSH = 2'b10,
        FIFO_BOTH = 2'b11
    } fifo_op_e;

    // Pointers and the level carry one extra bit so that full and empty can be told apart.
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/perf_trace_monitor_if.sv
// Valid/ready trace stream from the monitor (master) to its consumer (slave).
interface perf_trace_monitor_if
    import perf_trace_monitor_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) ();
    localparam int LVL_W = lvl_w(DEPTH);

    logic [DATA_W-1:0] trace_data;
    logic              trace_valid;
    logic              trace_ready;
    logic [LVL_W-1:0]  trace_level;

    modport master (
        output trace_data,
        output trace_valid,
        output trace_level,
        input  trace_ready
    );

    modport slave (
        input  trace_data,
        input  trace_valid,
        input  trace_level,
        output trace_ready
    );

endinterface

// File: rtl/perf_trace_monitor_trace_fifo.sv
// First-word-fall-through synchronous FIFO holding fetch words for the trace consumer.
module perf_trace_monitor_trace_fifo
    import perf_trace_monitor_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    localparam int LVL_W = lvl_w(DEPTH)
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty,
    output logic [LVL_W-1:0]  level
);
    localparam int AW = LVL_W - 1;
    localparam logic [LVL_W-1:0] PTR_ONE = LVL_W'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [LVL_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [LVL_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic              push_ok, pop_ok;
    fifo_op_e          op;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign level = wr_ptr_reg - rd_ptr_reg;

    // A push into a full FIFO is only accepted when the head leaves on the same edge.
    assign pop_ok  = pop && !empty && !clr;
    assign push_ok = push && !clr && (!full || pop_ok);
    assign op      = fifo_op_e'({push_ok, pop_ok});

    // Head is forced to zero while empty so the stream reads zero after reset or flush.
    assign rdata = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        case (op)
            FIFO_PUSH: wr_ptr_next = wr_ptr_reg + PTR_ONE;
            FIFO_POP:  rd_ptr_next = rd_ptr_reg + PTR_ONE;
            FIFO_BOTH: begin
                wr_ptr_next = wr_ptr_reg + PTR_ONE;
                rd_ptr_next = rd_ptr_reg + PTR_ONE;
            end
            default: ;
        endcase
        if (clr) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_ptr_reg[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/perf_trace_monitor.sv
// Passive observer of the stage_7 CPU: cycle/instruction counters plus a trace FIFO
// of the MemOut word seen on every fetch cycle.
module perf_trace_monitor
    import perf_trace_monitor_pkg::*;
#(
    parameter int                   DATA_W      = DATA_W_DEF,
    parameter int                   STATE_W     = STATE_W_DEF,
    parameter logic [STATE_W-1:0]   FETCH_STATE = '0,
    parameter int                   CNT_W       = CNT_W_DEF,
    parameter int                   DEPTH       = DEPTH_DEF
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 clr,
    input  logic [STATE_W-1:0]   state,
    input  logic [DATA_W-1:0]    MemOut,
    output logic [CNT_W-1:0]     cycle_count,
    output logic [CNT_W-1:0]     instr_count,
    output logic                 overflow,
    perf_trace_monitor_if.master trace
);
    localparam int LVL_W = lvl_w(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0]  cycle_count_reg, cycle_count_next;
    logic [CNT_W-1:0]  instr_count_reg, instr_count_next;
    logic              overflow_reg, overflow_next;
    logic              fetch, pop, fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_rdata;
    logic [LVL_W-1:0]  fifo_level;

    assign fetch = en && (state == FETCH_STATE);
    assign pop   = trace.trace_valid && trace.trace_ready;

    perf_trace_monitor_trace_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_trace_fifo (
        .CLK   (CLK),
        .reset (reset),
        .clr   (clr),
        .push  (fetch),
        .pop   (pop),
        .wdata (MemOut),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Counters stop at all-ones so a long run never reports a small wrapped value.
    always_comb begin
        cycle_count_next = cycle_count_reg;
        instr_count_next = instr_count_reg;
        overflow_next    = overflow_reg;
        if (clr) begin
            cycle_count_next = '0;
            instr_count_next = '0;
            overflow_next    = 1'b0;
        end else begin
            if (en && (cycle_count_reg != '1)) begin
                cycle_count_next = cycle_count_reg + CNT_ONE;
            end
            if (fetch && (instr_count_reg != '1)) begin
                instr_count_next = instr_count_reg + CNT_ONE;
            end
            if (fetch && fifo_full && !trace.trace_ready) begin
                overflow_next = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            cycle_count_reg <= '0;
            instr_count_reg <= '0;
            overflow_reg    <= 1'b0;
        end else begin
            cycle_count_reg <= cycle_count_next;
            instr_count_reg <= instr_count_next;
            overflow_reg    <= overflow_next;
        end
    end

    assign cycle_count       = cycle_count_reg;
    assign instr_count       = instr_count_reg;
    assign overflow          = overflow_reg;
    assign trace.trace_data  = fifo_rdata;
    assign trace.trace_valid = !fifo_empty;
    assign trace.trace_level = fifo_level;

endmodule
